// File: rtl/pipeline_pkg.sv
// Shared hazard-unit types: field widths, forward-select encodings and the
// per-stage write/read record carried down the E/M/W shadow pipeline.
package pipeline_pkg;

    localparam int ADDR_W = 5;
    localparam int T_W    = 2;

    localparam logic [1:0] FWD_D_GRF = 2'd0;
    localparam logic [1:0] FWD_D_E   = 2'd1;
    localparam logic [1:0] FWD_D_M   = 2'd2;
    localparam logic [1:0] FWD_D_W   = 2'd3;

    localparam logic [1:0] FWD_E_REG = 2'd0;
    localparam logic [1:0] FWD_E_M   = 2'd1;
    localparam logic [1:0] FWD_E_W   = 2'd2;

    localparam logic FWD_M_REG = 1'b0;
    localparam logic FWD_M_W   = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [T_W-1:0]    tnew;
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
    } hazard_rec_t;

    localparam hazard_rec_t BUBBLE = '0;

    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // A stage can supply a reader only once its result already exists.
    function automatic logic fwd_hit(input hazard_rec_t r, input logic [ADDR_W-1:0] a);
        return (a != '0) && (r.wa == a) && (r.tnew == '0);
    endfunction

    function automatic logic stall_hit(input hazard_rec_t r, input logic [ADDR_W-1:0] a,
                                       input logic [T_W-1:0] tuse);
        return (a != '0) && (r.wa == a) && (r.tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow-pipeline record register with bubble insert and optional
// saturating Tnew countdown on capture.
module hazard_stage_reg
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  logic        dec,
    input  hazard_rec_t d,
    output hazard_rec_t q
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            q <= BUBBLE;
        end else begin
            q.wa   <= d.wa;
            q.tnew <= dec ? tnew_dec(d.tnew) : d.tnew;
            q.ra1  <= d.ra1;
            q.ra2  <= d.ra2;
        end
    end

endmodule

// File: rtl/at_hazard_unit.sv
// Tuse/Tnew hazard unit: ID stall request and D/E/M forwarding selects.
// Optional HAZARD_PERF_EN adds stall_cnt and fwd_cnt event counters.
module at_hazard_unit #(
    parameter int ADDR_W = pipeline_pkg::ADDR_W,
    parameter int T_W    = pipeline_pkg::T_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1_ID,
    input  logic [ADDR_W-1:0] RA2_ID,
    input  logic [T_W-1:0]    Tuse_RA1,
    input  logic [T_W-1:0]    Tuse_RA2,
    input  logic [ADDR_W-1:0] WA_ID,
    input  logic [T_W-1:0]    Tnew,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    import pipeline_pkg::*;

    hazard_rec_t id_rec;
    hazard_rec_t rec_e;
    hazard_rec_t rec_m;
    hazard_rec_t rec_w;

    assign id_rec = '{wa: WA_ID, tnew: Tnew, ra1: RA1_ID, ra2: RA2_ID};

    // E holds Tnew as annotated; the countdown starts on the E->M move.
    hazard_stage_reg u_stage_e (
        .clk    (clk),
        .reset  (reset),
        .bubble (stall),
        .dec    (1'b0),
        .d      (id_rec),
        .q      (rec_e)
    );

    hazard_stage_reg u_stage_m (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .dec    (1'b1),
        .d      (rec_e),
        .q      (rec_m)
    );

    hazard_stage_reg u_stage_w (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .dec    (1'b1),
        .d      (rec_m),
        .q      (rec_w)
    );

    always_comb begin
        stall = stall_hit(rec_e, RA1_ID, Tuse_RA1) | stall_hit(rec_m, RA1_ID, Tuse_RA1) |
                stall_hit(rec_e, RA2_ID, Tuse_RA2) | stall_hit(rec_m, RA2_ID, Tuse_RA2);
    end

    // Nearest ready producer wins; a not-yet-ready match falls through.
    always_comb begin
        fwd_rs_d = FWD_D_GRF;
        if (fwd_hit(rec_e, RA1_ID))      fwd_rs_d = FWD_D_E;
        else if (fwd_hit(rec_m, RA1_ID)) fwd_rs_d = FWD_D_M;
        else if (fwd_hit(rec_w, RA1_ID)) fwd_rs_d = FWD_D_W;

        fwd_rt_d = FWD_D_GRF;
        if (fwd_hit(rec_e, RA2_ID))      fwd_rt_d = FWD_D_E;
        else if (fwd_hit(rec_m, RA2_ID)) fwd_rt_d = FWD_D_M;
        else if (fwd_hit(rec_w, RA2_ID)) fwd_rt_d = FWD_D_W;

        fwd_rs_e = FWD_E_REG;
        if (fwd_hit(rec_m, rec_e.ra1))      fwd_rs_e = FWD_E_M;
        else if (fwd_hit(rec_w, rec_e.ra1)) fwd_rs_e = FWD_E_W;

        fwd_rt_e = FWD_E_REG;
        if (fwd_hit(rec_m, rec_e.ra2))      fwd_rt_e = FWD_E_M;
        else if (fwd_hit(rec_w, rec_e.ra2)) fwd_rt_e = FWD_E_W;

        fwd_rt_m = fwd_hit(rec_w, rec_m.ra2) ? FWD_M_W : FWD_M_REG;
    end

`ifdef HAZARD_PERF_EN
    logic any_fwd;

    assign any_fwd = (fwd_rs_d != '0) | (fwd_rt_d != '0) | (fwd_rs_e != '0) |
                     (fwd_rt_e != '0) | fwd_rt_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall)   stall_cnt <= stall_cnt + 32'd1;
            if (any_fwd) fwd_cnt   <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_at_hazard_unit.sv
// Scoreboard bench for at_hazard_unit: directed hazard scenarios followed by
// randomized instruction streams, checked against an in-flight-age model.
module tb_at_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RA1_ID, RA2_ID, WA_ID;
    logic [1:0] Tuse_RA1, Tuse_RA2, Tnew;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       fwd_rt_m;

    always #5 clk = ~clk;

    at_hazard_unit dut (
        .clk      (clk),
        .reset    (reset),
        .RA1_ID   (RA1_ID),
        .RA2_ID   (RA2_ID),
        .Tuse_RA1 (Tuse_RA1),
        .Tuse_RA2 (Tuse_RA2),
        .WA_ID    (WA_ID),
        .Tnew     (Tnew),
        .stall    (stall),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e),
        .fwd_rt_m (fwd_rt_m)
    );

    typedef struct {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] ra1;
        logic [1:0] tu1;
        logic [4:0] ra2;
        logic [1:0] tu2;
    } ins_t;

    typedef struct {
        int stall;
        int rs_d;
        int rt_d;
        int rs_e;
        int rt_e;
        int rt_m;
    } exp_t;

    // In-flight instructions, youngest first: index = cycles since entering E.
    ins_t pipe[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic ins_t mk(int wa, int tn, int r1, int t1, int r2, int t2);
        ins_t i;
        i.wa = wa[4:0]; i.tnew = tn[1:0];
        i.ra1 = r1[4:0]; i.tu1 = t1[1:0];
        i.ra2 = r2[4:0]; i.tu2 = t2[1:0];
        return i;
    endfunction

    function automatic void clear_pipe();
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(mk(0, 0, 0, 0, 0, 0));
    endfunction

    function automatic int cycles_left(int age);
        int r;
        r = int'(pipe[age].tnew) - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit ready_at(int age, logic [4:0] a);
        return (a != 0) && (pipe[age].wa == a) && (cycles_left(age) == 0);
    endfunction

    function automatic bit must_wait(logic [4:0] a, logic [1:0] tuse);
        for (int age = 0; age < 2; age++)
            if (a != 0 && pipe[age].wa == a && cycles_left(age) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int src_d(logic [4:0] a);
        for (int age = 0; age < 3; age++) if (ready_at(age, a)) return age + 1;
        return 0;
    endfunction

    function automatic int src_e(logic [4:0] a);
        for (int age = 1; age < 3; age++) if (ready_at(age, a)) return age;
        return 0;
    endfunction

    function automatic exp_t predict(ins_t id);
        exp_t e;
        e.stall = (must_wait(id.ra1, id.tu1) || must_wait(id.ra2, id.tu2)) ? 1 : 0;
        e.rs_d  = src_d(id.ra1);
        e.rt_d  = src_d(id.ra2);
        e.rs_e  = src_e(pipe[0].ra1);
        e.rt_e  = src_e(pipe[0].ra2);
        e.rt_m  = ready_at(2, pipe[1].ra2) ? 1 : 0;
        return e;
    endfunction

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    // One cycle: present inputs, queue the expected response, then retire the edge.
    task automatic apply(input bit rst, input ins_t ins, output int st);
        exp_t e;
        reset = rst;
        RA1_ID = ins.ra1; Tuse_RA1 = ins.tu1;
        RA2_ID = ins.ra2; Tuse_RA2 = ins.tu2;
        WA_ID = ins.wa;   Tnew = ins.tnew;
        e = predict(ins);
        exp_q.push_back(e);
        st = e.stall;
        @(posedge clk);
        if (rst) begin
            clear_pipe();
        end else begin
            pipe.push_front(st != 0 ? mk(0, 0, 0, 0, 0, 0) : ins);
            void'(pipe.pop_back());
        end
        #1;
    endtask

    // The datapath holds ID while stalled, so repeat until the instruction enters E.
    task automatic issue(input ins_t ins);
        int st;
        int n;
        n = 0;
        apply(1'b0, ins, st);
        while (st != 0 && n < 4) begin
            apply(1'b0, ins, st);
            n++;
        end
        if (st != 0) begin
            checks++;
            errors++;
            $display("FAIL stall_bound actual=stuck required=cleared at %0t", $time);
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(mk(0, 0, 0, 3, 0, 3));
    endtask

    exp_t e_mon;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("stall",    int'(stall),    e_mon.stall);
            chk("fwd_rs_d", int'(fwd_rs_d), e_mon.rs_d);
            chk("fwd_rt_d", int'(fwd_rt_d), e_mon.rt_d);
            chk("fwd_rs_e", int'(fwd_rs_e), e_mon.rs_e);
            chk("fwd_rt_e", int'(fwd_rt_e), e_mon.rt_e);
            chk("fwd_rt_m", int'(fwd_rt_m), e_mon.rt_m);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        ins_t r;
        reset = 1'b1;
        RA1_ID = '0; RA2_ID = '0; WA_ID = '0;
        Tuse_RA1 = '0; Tuse_RA2 = '0; Tnew = '0;
        clear_pipe();
        @(posedge clk);
        #1;

        // load-use with Tuse=1
        issue(mk(8, 2, 29, 1, 0, 3));
        issue(mk(10, 1, 8, 1, 9, 1));
        nops(3);
        // load then branch compare
        issue(mk(8, 2, 29, 1, 0, 3));
        issue(mk(0, 0, 8, 0, 0, 0));
        nops(3);
        // ALU result feeding store data
        issue(mk(9, 1, 1, 1, 2, 1));
        issue(mk(0, 0, 29, 1, 9, 2));
        nops(3);
        // jal then jr $31
        issue(mk(31, 0, 0, 3, 0, 3));
        issue(mk(0, 0, 31, 0, 0, 3));
        nops(3);
        // $0 is never a hazard
        issue(mk(0, 2, 1, 1, 0, 3));
        issue(mk(3, 1, 0, 0, 0, 0));
        nops(3);
        // reset during a load-use stall
        issue(mk(8, 2, 29, 1, 0, 3));
        apply(1'b0, mk(10, 1, 8, 1, 9, 1), st);
        apply(1'b1, mk(10, 1, 8, 1, 9, 1), st);
        issue(mk(10, 1, 8, 1, 9, 1));
        nops(3);

        for (int k = 0; k < 400; k++) begin
            r = mk($urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) apply(1'b1, r, st);
            else issue(r);
        end
        nops(3);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
